// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative MULT/MULTU/DIV/DIVU unit that owns HI/LO.
// Optional early multiply exit is enabled with MULDIV_EARLY_TERM_EN.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    FIX,
    FINISH
  } state_t;

  state_t state, state_n;

  logic [1:0]         op_q;
  logic               sign_q;
  logic               sign_r;
  logic               divz;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quo;
  logic [CW-1:0]      cnt;

  logic               last;
  logic               early;
  logic [WIDTH-1:0]   a_abs;
  logic [WIDTH-1:0]   b_abs;
  logic [WIDTH:0]     psum;
  logic [WIDTH:0]     trial;
  logic               ge;
  logic [2*WIDTH-1:0] m_res;
  logic [WIDTH-1:0]   q_res;
  logic [WIDTH-1:0]   r_res;

  assign a_abs = (op[0] && a[WIDTH-1]) ? -a : a;
  assign b_abs = (op[0] && b[WIDTH-1]) ? -b : b;
  assign last  = (cnt == CW'(WIDTH - 1));

  // one multiply step adds the multiplicand when the multiplier LSB is set
  assign psum = {1'b0, prod[2*WIDTH-1:WIDTH]}
              + (prod[0] ? {1'b0, opnd} : '0);

  // one restoring divide step on a WIDTH+1 bit partial remainder
  assign trial = {rem, quo[WIDTH-1]};
  assign ge    = (trial >= {1'b0, opnd});

  // zero divisor keeps an all-ones quotient regardless of sign
  assign m_res = sign_q ? -prod : prod;
  assign q_res = (sign_q && !divz) ? -quo : quo;
  assign r_res = sign_r ? -rem : rem;

`ifdef MULDIV_EARLY_TERM_EN
  logic [CW:0]      left;
  logic [WIDTH-1:0] lowmask;

  // low 'left' bits of prod are the multiplier bits not yet consumed
  assign left    = (CW + 1)'(WIDTH) - {1'b0, cnt};
  assign lowmask = ~({WIDTH{1'b1}} << left);
  assign early   = (state == ITER) && (op_q == 2'b00)
                && ((prod[WIDTH-1:0] & lowmask) == '0);
`else
  assign early = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // next state and status outputs
  always_comb begin
    state_n = state;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_n = ITER;
      end
      ITER: begin
        busy = 1'b1;
        if (last || early) state_n = FIX;
      end
      FIX: begin
        busy    = 1'b1;
        state_n = FINISH;
      end
      FINISH: begin
        done    = 1'b1;
        state_n = IDLE;
      end
    endcase
  end

  // operand capture, iteration datapath and HI/LO writes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q   <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      divz   <= 1'b0;
      opnd   <= '0;
      prod   <= '0;
      rem    <= '0;
      quo    <= '0;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            op_q   <= op;
            sign_q <= op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
            sign_r <= op[0] & a[WIDTH-1];
            divz   <= (b == '0);
            opnd   <= op[1] ? b_abs : a_abs;
            prod   <= {{WIDTH{1'b0}}, b_abs};
            quo    <= a_abs;
            rem    <= '0;
            cnt    <= '0;
          end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
          end
        end
        ITER: begin
          cnt <= last ? '0 : cnt + 1'b1;
          if (op_q[1]) begin
            rem <= ge ? WIDTH'(trial - {1'b0, opnd})
                      : trial[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], ge};
          end else begin
`ifdef MULDIV_EARLY_TERM_EN
            if (early) prod <= prod >> left;
            else       prod <= {psum, prod[WIDTH-1:1]};
`else
            prod <= {psum, prod[WIDTH-1:1]};
`endif
          end
        end
        FIX: begin
          if (op_q[1]) begin
            hi <= r_res;
            lo <= q_res;
          end else begin
            hi <= m_res[2*WIDTH-1:WIDTH];
            lo <= m_res[WIDTH-1:0];
          end
        end
        FINISH: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed vectors for muldiv_seq.
// Inputs change 1ns after the rising edge; outputs sampled there too.
module tb_muldiv_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int compared;
  int mismatched;

  muldiv_seq #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .hi_we (hi_we),
    .lo_we (lo_we),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [1:0] o,
                        input logic [31:0] x,
                        input logic [31:0] y);
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    tick();
    start = 1'b0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    a     = $urandom;
    b     = $urandom;
  endtask

  task automatic finish(input string tag,
                        input logic [31:0] eh,
                        input logic [31:0] el,
                        input int elat);
    int n;
    int bad;
    n   = 1;
    bad = 0;
    while (done !== 1'b1 && n < 60) begin
      if (busy !== 1'b1) bad++;
      tick();
      n++;
    end
    check({tag, "_lat"}, 32'(n), 32'(elat));
    check({tag, "_busy"}, 32'(bad), 32'd0);
    check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    check({tag, "_hi"}, hi, eh);
    check({tag, "_lo"}, lo, el);
    tick();
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
  endtask

  task automatic do_op(input string tag,
                       input logic [1:0] o,
                       input logic [31:0] x,
                       input logic [31:0] y,
                       input logic [31:0] eh,
                       input logic [31:0] el);
    launch(o, x, y);
    finish(tag, eh, el, 34);
  endtask

  initial begin
    int pulses;
    compared   = 0;
    mismatched = 0;
    reset = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    a     = '0;
    b     = '0;
    hi_we = 1'b0;
    lo_we = 1'b0;
    wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);

    do_op("multu_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF,
          32'hFFFFFFFE, 32'h00000001);
    do_op("mult_neg", 2'b01, 32'hFFFFFFF9, 32'd3,
          32'hFFFFFFFF, 32'hFFFFFFEB);
    do_op("mult_nn", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF,
          32'h00000000, 32'h00000001);
    do_op("div_neg", 2'b11, 32'hFFFFFFF9, 32'd2,
          32'hFFFFFFFF, 32'hFFFFFFFD);
    do_op("div_negb", 2'b11, 32'd7, 32'hFFFFFFFE,
          32'h00000001, 32'hFFFFFFFD);
    do_op("divu", 2'b10, 32'd100, 32'd7,
          32'd2, 32'd14);
    do_op("div_ovf", 2'b11, 32'h80000000, 32'hFFFFFFFF,
          32'h00000000, 32'h80000000);
    do_op("divu_z", 2'b10, 32'd5, 32'd0,
          32'd5, 32'hFFFFFFFF);
    do_op("div_z", 2'b11, 32'hFFFFFFFB, 32'd0,
          32'hFFFFFFFB, 32'hFFFFFFFF);

    lo_we = 1'b1;
    wdata = 32'h1234;
    tick();
    lo_we = 1'b0;
    check("mtlo_lo", lo, 32'h1234);
    check("mtlo_hi", hi, 32'hFFFFFFFB);

    hi_we = 1'b1;
    lo_we = 1'b1;
    wdata = 32'hCAFE;
    tick();
    hi_we = 1'b0;
    lo_we = 1'b0;
    check("mt_both_hi", hi, 32'hCAFE);
    check("mt_both_lo", lo, 32'hCAFE);

    hi_we = 1'b1;
    wdata = 32'hAAAA;
    launch(2'b00, 32'd2, 32'hC0000003);
    check("we_at_start", hi, 32'hCAFE);
    finish("multu_small", 32'h00000001, 32'h80000006, 34);

    launch(2'b10, 32'd100, 32'd7);
    pulses = 0;
    for (int c = 1; c <= 45; c++) begin
      if (done === 1'b1) pulses++;
      if (c == 6) check("mthi_busy", hi, 32'h00000001);
      hi_we = (c == 5);
      start = (c == 10);
      if (c == 10) begin
        op = 2'b00;
        a  = 32'd3;
        b  = 32'd3;
      end
      wdata = 32'hDEAD;
      tick();
    end
    hi_we = 1'b0;
    start = 1'b0;
    check("busy_start_pulses", 32'(pulses), 32'd1);
    check("busy_start_hi", hi, 32'd2);
    check("busy_start_lo", lo, 32'd14);

    launch(2'b00, 32'hFFFFFFFF, 32'h80000001);
    repeat (14) tick();
    reset = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    do_op("after_rst", 2'b00, 32'h12345678, 32'h80000000,
          32'h091A2B3C, 32'h00000000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
